// File: rtl/neighbor_table_ctrl.sv
// Neighbor table sequencer: insert-or-update by node ID and best-Q next-hop scan.
// Optional macro NT_ENERGY_TIEBREAK_EN adds energy/hops tie-breaking on equal Q (one extra compare stage).
module neighbor_table_ctrl #(
    parameter int WORD_WIDTH  = 16,
    parameter int TABLE_DEPTH = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [WORD_WIDTH-1:0]     upd_id,
    input  logic [WORD_WIDTH-1:0]     upd_hops,
    input  logic [WORD_WIDTH-1:0]     upd_qvalue,
    input  logic [WORD_WIDTH-1:0]     upd_energy,
    input  logic [WORD_WIDTH-1:0]     upd_ch,
    input  logic [WORD_WIDTH-1:0]     upd_chhops,
    output logic                      upd_done,
    output logic                      upd_drop,
    input  logic                      best_start,
    output logic                      best_done,
    output logic                      best_found,
    output logic [WORD_WIDTH-1:0]     best_id,
    output logic [WORD_WIDTH-1:0]     best_qvalue,
    output logic [WORD_WIDTH-1:0]     best_hops,
    input  logic                      clear,
    output logic                      busy,
    output logic [ADDR_WIDTH:0]       neighbor_count,
    output logic                      table_full,
    output logic [ADDR_WIDTH-1:0]     tbl_addr,
    output logic                      tbl_rd_en,
    output logic                      tbl_wr_en,
    output logic [6*WORD_WIDTH-1:0]   tbl_wdata,
    input  logic [6*WORD_WIDTH-1:0]   tbl_rdata
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TABLE_DEPTH);
`ifdef NT_ENERGY_TIEBREAK_EN
    localparam int STAGES = 1;
`else
    localparam int STAGES = 0;
`endif

    typedef struct packed {
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] q;
        logic [WORD_WIDTH-1:0] energy;
        logic [WORD_WIDTH-1:0] ch;
        logic [WORD_WIDTH-1:0] chhops;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE, UPD_SCAN, UPD_WRITE, BEST_SCAN, BEST_FINISH
    } state_t;

    state_t state, state_nxt;

    entry_t                 ent;
    entry_t                 rd_ent;
    entry_t                 cmp_ent;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          rd_idx;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic                   upd_new;
    logic                   drop_f;

    // vld_pipe[0]: tbl_rdata valid; vld_pipe[STAGES]: best-scan compare input valid
    logic [STAGES:0]          vld_pipe;
    logic [STAGES:0][CW-1:0]  idx_pipe;

    logic                   run_found;
    logic [WORD_WIDTH-1:0]  run_id;
    logic [WORD_WIDTH-1:0]  run_q;
    logic [WORD_WIDTH-1:0]  run_hops;
`ifdef NT_ENERGY_TIEBREAK_EN
    logic [WORD_WIDTH-1:0]  run_energy;
    entry_t                 rd_q;
`endif

    logic upd_match, upd_last, best_vld, best_last, better;
    logic unused_bits;

    assign rd_ent = entry_t'(tbl_rdata);
`ifdef NT_ENERGY_TIEBREAK_EN
    assign cmp_ent = rd_q;
`else
    assign cmp_ent = rd_ent;
`endif
    assign unused_bits = ^{rd_ent.ch, rd_ent.chhops, rd_ent.energy};

    assign upd_match = vld_pipe[0] && (rd_ent.id == ent.id);
    assign upd_last  = vld_pipe[0] && (idx_pipe[0] == cnt - CW'(1));
    assign best_vld  = vld_pipe[STAGES];
    assign best_last = best_vld && (idx_pipe[STAGES] == cnt - CW'(1));

`ifdef NT_ENERGY_TIEBREAK_EN
    assign better = !run_found || (cmp_ent.q > run_q) ||
                    ((cmp_ent.q == run_q) &&
                     ((cmp_ent.energy > run_energy) ||
                      ((cmp_ent.energy == run_energy) && (cmp_ent.hops < run_hops))));
`else
    assign better = !run_found || (cmp_ent.q > run_q);
`endif

    always_comb begin
        tbl_rd_en = 1'b0;
        case (state)
            UPD_SCAN, BEST_SCAN: tbl_rd_en = (rd_idx < cnt);
            default:             tbl_rd_en = 1'b0;
        endcase
    end

    assign tbl_wr_en      = (state == UPD_WRITE) && !drop_f;
    assign upd_done       = (state == UPD_WRITE) && !drop_f;
    assign upd_drop       = (state == UPD_WRITE) && drop_f;
    assign best_done      = (state == BEST_FINISH);
    assign busy           = (state != IDLE);
    assign upd_ready      = (state == IDLE) && !nrst;
    assign neighbor_count = cnt;
    assign table_full     = (cnt == DEPTH_C);
    assign tbl_wdata      = ent;
    assign tbl_addr       = tbl_rd_en ? rd_idx[ADDR_WIDTH-1:0] :
                            tbl_wr_en ? wr_addr : '0;

    always_ff @(posedge clk) begin
        if (nrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear)           state_nxt = IDLE;
                else if (upd_valid)  state_nxt = (cnt == '0) ? UPD_WRITE : UPD_SCAN;
                else if (best_start) state_nxt = (cnt == '0) ? BEST_FINISH : BEST_SCAN;
            end
            UPD_SCAN:    if (upd_match || upd_last) state_nxt = UPD_WRITE;
            UPD_WRITE:   state_nxt = IDLE;
            BEST_SCAN:   if (best_last) state_nxt = BEST_FINISH;
            BEST_FINISH: state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            ent         <= '0;
            cnt         <= '0;
            rd_idx      <= '0;
            wr_addr     <= '0;
            upd_new     <= 1'b0;
            drop_f      <= 1'b0;
            vld_pipe    <= '0;
            idx_pipe    <= '0;
            run_found   <= 1'b0;
            run_id      <= '0;
            run_q       <= '0;
            run_hops    <= '0;
            best_found  <= 1'b0;
            best_id     <= '0;
            best_qvalue <= '0;
            best_hops   <= '0;
`ifdef NT_ENERGY_TIEBREAK_EN
            run_energy  <= '0;
            rd_q        <= '0;
`endif
        end else begin
            vld_pipe[0] <= tbl_rd_en;
            idx_pipe[0] <= rd_idx;
`ifdef NT_ENERGY_TIEBREAK_EN
            vld_pipe[1] <= vld_pipe[0];
            idx_pipe[1] <= idx_pipe[0];
            rd_q        <= rd_ent;
`endif
            if (tbl_rd_en) rd_idx <= rd_idx + CW'(1);

            case (state)
                IDLE: begin
                    if (clear) begin
                        cnt <= '0;
                    end else if (upd_valid) begin
                        ent     <= '{upd_id, upd_hops, upd_qvalue, upd_energy, upd_ch, upd_chhops};
                        rd_idx  <= '0;
                        wr_addr <= '0;
                        upd_new <= 1'b1;
                        drop_f  <= 1'b0;
                    end else if (best_start) begin
                        rd_idx    <= '0;
                        run_found <= 1'b0;
                        run_id    <= '0;
                        run_q     <= '0;
                        run_hops  <= '0;
`ifdef NT_ENERGY_TIEBREAK_EN
                        run_energy <= '0;
`endif
                        if (cnt == '0) begin
                            best_found  <= 1'b0;
                            best_id     <= '0;
                            best_qvalue <= '0;
                            best_hops   <= '0;
                        end
                    end
                end
                UPD_SCAN: begin
                    if (upd_match) begin
                        wr_addr <= idx_pipe[0][ADDR_WIDTH-1:0];
                        upd_new <= 1'b0;
                    end else if (upd_last) begin
                        wr_addr <= cnt[ADDR_WIDTH-1:0];
                        upd_new <= 1'b1;
                        drop_f  <= (cnt == DEPTH_C);
                    end
                end
                UPD_WRITE: begin
                    if (!drop_f && upd_new) cnt <= cnt + CW'(1);
                end
                BEST_SCAN: begin
                    if (best_vld && better) begin
                        run_found <= 1'b1;
                        run_id    <= cmp_ent.id;
                        run_q     <= cmp_ent.q;
                        run_hops  <= cmp_ent.hops;
`ifdef NT_ENERGY_TIEBREAK_EN
                        run_energy <= cmp_ent.energy;
`endif
                    end
                    // final compare lands straight in the held result registers
                    if (best_last) begin
                        best_found  <= 1'b1;
                        best_id     <= better ? cmp_ent.id   : run_id;
                        best_qvalue <= better ? cmp_ent.q    : run_q;
                        best_hops   <= better ? cmp_ent.hops : run_hops;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
